// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - state encoding and source-index width helper for sdram_port_arbiter
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_XFER    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_t;

  function automatic int src_idx_w(input int num_ports);
    return (2 * num_ports > 1) ? $clog2(2 * num_ports) : 1;
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_rr_pick.sv
// rtl/sdram_port_arbiter_rr_pick.sv - rotating-priority encoder: first requester at or after ptr
module rr_pick #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         valid
);

  logic [W-1:0] cand;

  // Scan from the farthest offset down so the nearest requester is the last to win.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = W'((int'(ptr) + i) % N);
      if (req[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - N-port round-robin front-end for the SDRAM controller
// SDRAM_ARB_PRIO_EN: source 1 (port 0 read) gets fixed priority and does not move the pointer.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 16,
  parameter int BURST_W   = 10,
  localparam int SRC_IDX_W = src_idx_w(NUM_PORTS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      init_done,
  input  logic [NUM_PORTS-1:0]      wr_req,
  output logic [NUM_PORTS-1:0]      wr_ack,
  input  logic [NUM_PORTS*ADDR_W-1:0]  wr_addr,
  input  logic [NUM_PORTS*BURST_W-1:0] wr_burst,
  input  logic [NUM_PORTS*DATA_W-1:0]  wr_din,
  input  logic [NUM_PORTS-1:0]      rd_req,
  output logic [NUM_PORTS-1:0]      rd_ack,
  input  logic [NUM_PORTS*ADDR_W-1:0]  rd_addr,
  input  logic [NUM_PORTS*BURST_W-1:0] rd_burst,
  output logic [DATA_W-1:0]         rd_dout,
  output logic                      ctrl_wr_req,
  output logic                      ctrl_rd_req,
  input  logic                      ctrl_wr_ack,
  input  logic                      ctrl_rd_ack,
  output logic [ADDR_W-1:0]         ctrl_wr_addr,
  output logic [ADDR_W-1:0]         ctrl_rd_addr,
  output logic [BURST_W-1:0]        ctrl_wr_burst,
  output logic [BURST_W-1:0]        ctrl_rd_burst,
  output logic [DATA_W-1:0]         ctrl_din,
  input  logic [DATA_W-1:0]         ctrl_dout,
  output logic [SRC_IDX_W-1:0]      grant_idx,
  output logic                      busy
);

  localparam int NUM_SRC = 2 * NUM_PORTS;
  localparam int PORT_W  = SRC_IDX_W - 1;

  arb_state_t           state, state_nxt;
  logic [SRC_IDX_W-1:0] rr_ptr, rr_ptr_nxt, grant_nxt;
  logic [SRC_IDX_W-1:0] pick_idx, sel_idx;
  logic                 pick_valid;
  logic [NUM_SRC-1:0]   src_req;
  logic [PORT_W-1:0]    gport;
  logic                 grant_rd, active, cur_ack;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_src
    assign src_req[2*p]   = wr_req[p];
    assign src_req[2*p+1] = rd_req[p];
  end

  rr_pick #(.N(NUM_SRC), .W(SRC_IDX_W)) u_pick (
    .req   (src_req),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

`ifdef SDRAM_ARB_PRIO_EN
  assign sel_idx = src_req[1] ? SRC_IDX_W'(1) : pick_idx;
`else
  assign sel_idx = pick_idx;
`endif

  assign gport    = grant_idx[SRC_IDX_W-1:1];
  assign grant_rd = grant_idx[0];
  assign active   = (state == ST_REQ) || (state == ST_XFER);
  assign cur_ack  = grant_rd ? ctrl_rd_ack : ctrl_wr_ack;

  assign busy        = active;
  assign ctrl_wr_req = active && !grant_rd;
  assign ctrl_rd_req = active && grant_rd;

  assign ctrl_wr_addr  = wr_addr[gport*ADDR_W +: ADDR_W];
  assign ctrl_rd_addr  = rd_addr[gport*ADDR_W +: ADDR_W];
  assign ctrl_wr_burst = wr_burst[gport*BURST_W +: BURST_W];
  assign ctrl_rd_burst = rd_burst[gport*BURST_W +: BURST_W];
  assign ctrl_din      = wr_din[gport*DATA_W +: DATA_W];
  assign rd_dout       = ctrl_dout;

  // The first ack beat can land while still in REQ, so the pass-through covers both states.
  assign wr_ack = (active && !grant_rd && ctrl_wr_ack) ? (NUM_PORTS'(1) << gport) : '0;
  assign rd_ack = (active &&  grant_rd && ctrl_rd_ack) ? (NUM_PORTS'(1) << gport) : '0;

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant_idx;
    rr_ptr_nxt = rr_ptr;
    case (state)
      ST_IDLE: begin
        if (init_done && pick_valid) begin
          grant_nxt = sel_idx;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (cur_ack) state_nxt = ST_XFER;
      end
      ST_XFER: begin
        if (!cur_ack) state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        state_nxt  = ST_IDLE;
        rr_ptr_nxt = (grant_idx == SRC_IDX_W'(NUM_SRC - 1)) ? '0 : grant_idx + SRC_IDX_W'(1);
`ifdef SDRAM_ARB_PRIO_EN
        if (grant_idx == SRC_IDX_W'(1)) rr_ptr_nxt = rr_ptr;
`endif
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      grant_idx <= '0;
      rr_ptr    <= '0;
    end else begin
      state     <= state_nxt;
      grant_idx <= grant_nxt;
      rr_ptr    <= rr_ptr_nxt;
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - scoreboard bench for sdram_port_arbiter
`timescale 1ns/1ps
module tb_sdram_port_arbiter;

  localparam int NP = 4;
  localparam int AW = 24;
  localparam int DW = 16;
  localparam int BW = 10;
  localparam int NS = 8;

  logic              clk = 1'b0;
  logic              rst, init_done;
  logic [NP-1:0]     wr_req, wr_ack, rd_req, rd_ack;
  logic [NP*AW-1:0]  wr_addr, rd_addr;
  logic [NP*BW-1:0]  wr_burst, rd_burst;
  logic [NP*DW-1:0]  wr_din;
  logic [DW-1:0]     rd_dout, ctrl_din, ctrl_dout;
  logic              ctrl_wr_req, ctrl_rd_req, ctrl_wr_ack, ctrl_rd_ack;
  logic [AW-1:0]     ctrl_wr_addr, ctrl_rd_addr;
  logic [BW-1:0]     ctrl_wr_burst, ctrl_rd_burst;
  logic [2:0]        grant_idx;
  logic              busy;

  logic [AW-1:0] src_addr  [NS];
  logic [BW-1:0] src_burst [NS];

  typedef struct {
    int          idx;
    logic [AW-1:0] addr;
    int          burst;
  } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar p = 0; p < NP; p++) begin : g_src
    assign wr_addr[p*AW +: AW]  = src_addr[2*p];
    assign rd_addr[p*AW +: AW]  = src_addr[2*p+1];
    assign wr_burst[p*BW +: BW] = src_burst[2*p];
    assign rd_burst[p*BW +: BW] = src_burst[2*p+1];
    assign wr_din[p*DW +: DW]   = 16'hD000 + 16'(p);
  end

  sdram_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .BURST_W(BW)) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .wr_req(wr_req), .wr_ack(wr_ack), .wr_addr(wr_addr), .wr_burst(wr_burst), .wr_din(wr_din),
    .rd_req(rd_req), .rd_ack(rd_ack), .rd_addr(rd_addr), .rd_burst(rd_burst), .rd_dout(rd_dout),
    .ctrl_wr_req(ctrl_wr_req), .ctrl_rd_req(ctrl_rd_req),
    .ctrl_wr_ack(ctrl_wr_ack), .ctrl_rd_ack(ctrl_rd_ack),
    .ctrl_wr_addr(ctrl_wr_addr), .ctrl_rd_addr(ctrl_rd_addr),
    .ctrl_wr_burst(ctrl_wr_burst), .ctrl_rd_burst(ctrl_rd_burst),
    .ctrl_din(ctrl_din), .ctrl_dout(ctrl_dout),
    .grant_idx(grant_idx), .busy(busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int s);
    exp_t e;
    e.idx   = s;
    e.addr  = src_addr[s];
    e.burst = int'(src_burst[s]);
    exp_q.push_back(e);
  endtask

  task automatic set_req(input int s, input logic v);
    if (s % 2 == 0) wr_req[2'(s / 2)] = v;
    else            rd_req[2'(s / 2)] = v;
  endtask

  function automatic logic src_ack(input int s);
    return (s % 2 == 0) ? wr_ack[2'(s / 2)] : rd_ack[2'(s / 2)];
  endfunction

  // A source: raise req, wait for n ack windows, drop req the cycle after the last one ends.
  task automatic serve(input int s, input int n);
    int t;
    set_req(s, 1'b1);
    for (int b = 0; b < n; b++) begin
      t = 0;
      while (!src_ack(s) && t < 3000) begin @(negedge clk); t++; end
      check($sformatf("ack_rise_src%0d", s), 64'(t < 3000), 64'd1);
      t = 0;
      while (src_ack(s) && t < 600) begin @(negedge clk); t++; end
      check($sformatf("ack_fall_src%0d", s), 64'(t < 600), 64'd1);
    end
    @(posedge clk); #1;
    set_req(s, 1'b0);
  endtask

  // Controller model: ack high for exactly 'burst' cycles, read data ramps from 0.
  logic is_rd;
  int   blen;
  initial begin
    ctrl_wr_ack = 1'b0;
    ctrl_rd_ack = 1'b0;
    ctrl_dout   = '0;
    forever begin
      @(negedge clk);
      if (!rst && (ctrl_wr_req || ctrl_rd_req)) begin
        is_rd = ctrl_rd_req;
        blen  = is_rd ? int'(ctrl_rd_burst) : int'(ctrl_wr_burst);
        @(posedge clk); #1;
        for (int i = 0; i < blen; i++) begin
          if (rst) break;
          if (is_rd) begin ctrl_rd_ack = 1'b1; ctrl_dout = DW'(i); end
          else ctrl_wr_ack = 1'b1;
          @(posedge clk); #1;
        end
        ctrl_wr_ack = 1'b0;
        ctrl_rd_ack = 1'b0;
        for (int k = 0; k < 8 && (ctrl_wr_req || ctrl_rd_req); k++) @(negedge clk);
      end
    end
  end

  // Monitor: pops the expected grant on each busy rise and audits the ack window.
  exp_t       cur;
  logic       in_burst = 1'b0, prev_busy = 1'b0, prev_a = 1'b0, a;
  int         beats, shape_err, mp;
  logic [NP-1:0] ew, er;
  always @(negedge clk) begin
    if (rst) begin
      in_burst  = 1'b0;
      prev_busy = 1'b0;
      prev_a    = 1'b0;
    end else begin
      if (busy && !prev_busy) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_grant: got grant %0d expected no grant", grant_idx);
        end else begin
          cur = exp_q.pop_front();
          check("grant_idx", 64'(grant_idx), 64'(cur.idx));
          if (cur.idx % 2 == 0) begin
            check("ctrl_wr_addr", 64'(ctrl_wr_addr), 64'(cur.addr));
            check("ctrl_wr_burst", 64'(ctrl_wr_burst), 64'(cur.burst));
          end else begin
            check("ctrl_rd_addr", 64'(ctrl_rd_addr), 64'(cur.addr));
            check("ctrl_rd_burst", 64'(ctrl_rd_burst), 64'(cur.burst));
          end
          in_burst  = 1'b1;
          beats     = 0;
          shape_err = 0;
          prev_a    = 1'b0;
        end
      end
      if (!busy && prev_busy)
        check("req_dropped_at_release", 64'(ctrl_wr_req | ctrl_rd_req), 64'd0);
      if (in_burst) begin
        mp = cur.idx / 2;
        ew = (cur.idx % 2 == 0 && ctrl_wr_ack) ? NP'(1 << mp) : '0;
        er = (cur.idx % 2 == 1 && ctrl_rd_ack) ? NP'(1 << mp) : '0;
        if (wr_ack !== ew || rd_ack !== er) shape_err++;
        a = src_ack(cur.idx);
        if (a) begin
          if (cur.idx % 2 == 1) begin
            if (rd_dout !== DW'(beats)) shape_err++;
          end else if (ctrl_din !== 16'hD000 + DW'(mp)) shape_err++;
          beats++;
        end
        if (prev_a && !a) begin
          check($sformatf("beats_src%0d", cur.idx), 64'(beats), 64'(cur.burst));
          check($sformatf("ack_data_src%0d", cur.idx), 64'(shape_err), 64'd0);
          in_burst = 1'b0;
        end
        prev_a = a;
      end
      prev_busy = busy;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog");
  end

  int n, t;
  initial begin
    for (int s = 0; s < NS; s++) begin
      src_addr[s]  = (s % 2 == 0) ? 24'h100000 + AW'(s * 16) : 24'h200000 + AW'(s * 16);
      src_burst[s] = BW'(s + 2);
    end
    rst = 1'b1; init_done = 1'b0; wr_req = 4'hF; rd_req = 4'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("nogrant_ctrl_wr_req", 64'(ctrl_wr_req), 64'd0);
    check("nogrant_ctrl_rd_req", 64'(ctrl_rd_req), 64'd0);
    check("nogrant_wr_ack", 64'(wr_ack), 64'd0);
    check("nogrant_rd_ack", 64'(rd_ack), 64'd0);
    check("nogrant_busy", 64'(busy), 64'd0);
    check("reset_grant_idx", 64'(grant_idx), 64'd0);
    @(posedge clk); #1;
    wr_req = 4'h0;
    init_done = 1'b1;

    // Long write burst on port 2.
    src_addr[4]  = 24'h012345;
    src_burst[4] = 10'd256;
    push(4);
    serve(4, 1);
    src_addr[4]  = 24'h100040;
    src_burst[4] = 10'd6;

    // Fresh pointer, all eight sources contending.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int s = 0; s < NS; s++) push(s);
    push(0);
    fork
      serve(0, 2); serve(1, 1); serve(2, 1); serve(3, 1);
      serve(4, 1); serve(5, 1); serve(6, 1); serve(7, 1);
    join

    // Read burst on port 1 with ramp data.
    src_burst[3] = 10'd16;
    push(3);
    serve(3, 1);

    // Reset at beat 10 of a port 0 write.
    src_burst[0] = 10'd20;
    push(0);
    @(posedge clk); #1 set_req(0, 1'b1);
    n = 0; t = 0;
    while (n < 10 && t < 200) begin @(negedge clk); if (wr_ack[0]) n++; t++; end
    check("rst_beat_reached", 64'(n), 64'd10);
    @(posedge clk); #1;
    rst = 1'b1;
    set_req(0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("rst_ctrl_wr_req", 64'(ctrl_wr_req), 64'd0);
    check("rst_ctrl_rd_req", 64'(ctrl_rd_req), 64'd0);
    check("rst_wr_ack", 64'(wr_ack), 64'd0);
    check("rst_rd_ack", 64'(rd_ack), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_grant_idx", 64'(grant_idx), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    src_burst[0] = 10'd2;

    // Pointer must restart at 0: source 2 before source 6.
    push(2); push(6);
    fork serve(2, 1); serve(6, 1); join

    // Source 4 alone moves the pointer to 5; then 1 and 6 contend.
    push(4);
    serve(4, 1);
`ifdef SDRAM_ARB_PRIO_EN
    push(1); push(6);
`else
    push(6); push(1);
`endif
    fork serve(1, 1); serve(6, 1); join

    // Serving source 1 alone either keeps the pointer (priority) or moves it to 2.
    push(1);
    serve(1, 1);
`ifdef SDRAM_ARB_PRIO_EN
    push(7); push(3);
`else
    push(3); push(7);
`endif
    fork serve(3, 1); serve(7, 1); join

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("final_busy", 64'(busy), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
